timer: RTL and testbench



---
 rtl/timer.sv | 193 +++++++++++++++++++
 tb/tb_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// Memory-mapped countdown timer (CTRL / PRESET / COUNT) with one-shot and auto-reload modes.
// Optional macro TIMER_PRESCALE_EN adds a CTRL[7:4] prescaler for the count rate.
module timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter logic [2:0]  WORD_MODE = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  input  logic [2:0]  dm_mode,
  input  logic        stop,
  input  logic        sel,
  output logic [31:0] read_result,
  output logic        valid,
  output logic        irq
);

  // Bus handshake: valid is a same-cycle legality flag with no ready; a write
  // commits on the next clock edge only when write_enable & valid & ~stop.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        en, en_n;
  logic [1:0]  mode, mode_n;
  logic        im, im_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        irq_pending, pend_n;

  logic [31:0] offset;
  logic        hit;
  logic        is_ctrl;
  logic        is_preset;
  logic        is_count;
  logic        commit;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en_eff;
  logic        ps_tick;

`ifdef TIMER_PRESCALE_EN
  logic [3:0]  ps, ps_n;
  logic [15:0] ps_cnt, ps_cnt_n;
  assign ps_tick = (ps_cnt == ((16'd1 << ps) - 16'd1));
`else
  assign ps_tick = 1'b1;
`endif

  // Offset arithmetic wraps addresses below BASE_ADDR to large values, so one compare covers both bounds.
  assign offset    = addr - BASE_ADDR;
  assign hit       = (offset < 32'd12) && (addr[1:0] == 2'b00);
  assign is_ctrl   = hit && (offset[3:2] == 2'd0);
  assign is_preset = hit && (offset[3:2] == 2'd1);
  assign is_count  = hit && (offset[3:2] == 2'd2);

  assign valid     = sel & hit & (dm_mode == WORD_MODE) & ~(write_enable & is_count);
  assign commit    = write_enable & valid & ~stop;
  assign wr_ctrl   = commit & is_ctrl;
  assign wr_preset = commit & is_preset;

  // EN as it will be after this edge, so a disabling write during LOAD skips the count.
  assign en_eff    = wr_ctrl ? write_data[0] : en;

  always_comb begin
    read_result = 32'd0;
    if (is_ctrl) begin
`ifdef TIMER_PRESCALE_EN
      read_result = {24'd0, ps, im, mode, en};
`else
      read_result = {28'd0, im, mode, en};
`endif
    end else if (is_preset) begin
      read_result = preset;
    end else if (is_count) begin
      read_result = count;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    en_n     = en;
    mode_n   = mode;
    im_n     = im;
    preset_n = preset;
    pend_n   = irq_pending;
`ifdef TIMER_PRESCALE_EN
    ps_n     = ps;
    ps_cnt_n = ps_cnt;
`endif

    if (wr_ctrl || wr_preset) begin
      pend_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (en) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        count_n = preset;
`ifdef TIMER_PRESCALE_EN
        ps_cnt_n = 16'd0;
`endif
        state_n = en_eff ? CNT : IDLE;
      end
      CNT: begin
        if (!en) begin
          state_n = IDLE;
        end else begin
          if (ps_tick) begin
            if (count > 32'd1) begin
              count_n = count - 32'd1;
            end else begin
              // A terminal count of 0 (PRESET=0) fires just like 1.
              count_n = 32'd0;
              pend_n  = 1'b1;
              state_n = INT;
            end
          end
`ifdef TIMER_PRESCALE_EN
          ps_cnt_n = ps_tick ? 16'd0 : ps_cnt + 16'd1;
`endif
        end
      end
      INT: begin
        state_n = IDLE;
        if (mode == 2'b01) begin
          pend_n = 1'b0;
        end else begin
          en_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // CPU CTRL write applied last so it overrides the one-shot EN clear.
    if (wr_ctrl) begin
      en_n   = write_data[0];
      mode_n = write_data[2:1];
      im_n   = write_data[3];
`ifdef TIMER_PRESCALE_EN
      ps_n   = write_data[7:4];
`endif
    end
    if (wr_preset) begin
      preset_n = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      en          <= 1'b0;
      mode        <= 2'd0;
      im          <= 1'b0;
      preset      <= 32'd0;
      count       <= 32'd0;
      irq_pending <= 1'b0;
      irq         <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      ps          <= 4'd0;
      ps_cnt      <= 16'd0;
`endif
    end else begin
      state       <= state_n;
      en          <= en_n;
      mode        <= mode_n;
      im          <= im_n;
      preset      <= preset_n;
      count       <= count_n;
      irq_pending <= pend_n;
      irq         <= im_n & pend_n;
`ifdef TIMER_PRESCALE_EN
      ps          <= ps_n;
      ps_cnt      <= ps_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: one-shot, auto-reload, access legality, disable,
// masking, same-edge CTRL write, reset and the prescale option.
module tb_timer;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'd4;
  localparam logic [31:0] A_CNT  = BASE + 32'd8;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [2:0]  dm_mode;
  logic        stop;
  logic        sel;
  logic [31:0] read_result;
  logic        valid;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer #(.BASE_ADDR(BASE), .WORD_MODE(3'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .dm_mode      (dm_mode),
    .stop         (stop),
    .sel          (sel),
    .read_result  (read_result),
    .valid        (valid),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_v, input string tag);
    addr = a; sel = 1'b1; write_enable = 1'b0; stop = 1'b0; dm_mode = 3'd0;
    #1;
    chk({tag, "_data"}, read_result, exp_d);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, exp_v});
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                        input logic s, input logic exp_v, input string tag);
    addr = a; write_data = d; write_enable = 1'b1; sel = 1'b1; dm_mode = m; stop = s;
    #1;
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, exp_v});
    @(posedge clk);
    #1;
    write_enable = 1'b0; stop = 1'b0; dm_mode = 3'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    bus_wr(a, d, 3'd0, 1'b0, 1'b1, tag);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; addr = '0; write_enable = 1'b0; write_data = '0;
    dm_mode = 3'd0; stop = 1'b0; sel = 1'b0;
    tick(2);
    rst = 1'b0;

    // Reset state
    chk_irq("rst_irq", 1'b0);
    rd(A_CTRL, 32'd0, 1'b1, "rst_ctrl");
    rd(A_PRE, 32'd0, 1'b1, "rst_pre");
    rd(A_CNT, 32'd0, 1'b1, "rst_cnt");

    // One-shot, IM=1, PRESET=5
    wr(A_PRE, 32'd5, "os_pre");
    wr(A_CTRL, 32'h9, "os_ctrl");
    tick(2);
    rd(A_CNT, 32'd5, 1'b1, "os_cnt_t2");
    tick(4);
    chk_irq("os_irq_t6", 1'b0);
    rd(A_CNT, 32'd1, 1'b1, "os_cnt_t6");
    tick(1);
    chk_irq("os_irq_t7", 1'b1);
    rd(A_CNT, 32'd0, 1'b1, "os_cnt_t7");
    rd(A_CTRL, 32'h9, 1'b1, "os_ctrl_t7");
    tick(1);
    rd(A_CTRL, 32'h8, 1'b1, "os_ctrl_t8");
    chk_irq("os_irq_t8", 1'b1);
    tick(3);
    chk_irq("os_irq_hold", 1'b1);
    rd(A_CNT, 32'd0, 1'b1, "os_cnt_hold");
    wr(A_PRE, 32'd5, "os_clear");
    chk_irq("os_irq_clr", 1'b0);

    // Auto-reload, PRESET=3: period 6
    wr(A_PRE, 32'd3, "ar_pre");
    wr(A_CTRL, 32'hB, "ar_ctrl");
    tick(2);
    for (int p = 0; p < 4; p++) begin
      rd(A_CNT, 32'd3, 1'b1, "ar_c3");
      chk_irq("ar_irq_c3", 1'b0);
      tick(1);
      rd(A_CNT, 32'd2, 1'b1, "ar_c2");
      tick(1);
      rd(A_CNT, 32'd1, 1'b1, "ar_c1");
      chk_irq("ar_irq_c1", 1'b0);
      tick(1);
      rd(A_CNT, 32'd0, 1'b1, "ar_c0");
      chk_irq("ar_irq_pulse", 1'b1);
      tick(1);
      chk_irq("ar_irq_idle", 1'b0);
      tick(1);
      chk_irq("ar_irq_load", 1'b0);
      tick(1);
    end
    wr(A_CTRL, 32'h0, "ar_stop");
    tick(2);
    rd(A_CNT, 32'd2, 1'b1, "ar_frozen");
    chk_irq("ar_irq_off", 1'b0);

    // Access legality
    bus_wr(A_CNT, 32'h1234, 3'd0, 1'b0, 1'b0, "wr_count");
    rd(A_CNT, 32'd2, 1'b1, "wr_count_keep");
    bus_wr(A_PRE, 32'h77, 3'd2, 1'b0, 1'b0, "wr_byte");
    rd(A_PRE, 32'd3, 1'b1, "wr_byte_keep");
    rd(BASE + 32'd2, 32'd0, 1'b0, "rd_misalign");
    bus_wr(A_PRE, 32'h55, 3'd0, 1'b1, 1'b1, "wr_stop");
    rd(A_PRE, 32'd3, 1'b1, "wr_stop_keep");
    rd(BASE + 32'd12, 32'd0, 1'b0, "rd_past_end");
    addr = A_PRE; write_data = 32'h99; write_enable = 1'b1; sel = 1'b0;
    #1;
    chk("nosel_valid", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #1;
    write_enable = 1'b0; sel = 1'b1;
    rd(A_PRE, 32'd3, 1'b1, "nosel_keep");

    // Disable mid-count, then re-enable reloads
    wr(A_PRE, 32'd100, "dis_pre");
    wr(A_CTRL, 32'h1, "dis_en");
    tick(2);
    rd(A_CNT, 32'd100, 1'b1, "dis_load");
    tick(10);
    rd(A_CNT, 32'd90, 1'b1, "dis_run");
    wr(A_CTRL, 32'h0, "dis_off");
    rd(A_CNT, 32'd89, 1'b1, "dis_last");
    tick(3);
    rd(A_CNT, 32'd89, 1'b1, "dis_frozen");
    chk_irq("dis_irq", 1'b0);
    wr(A_CTRL, 32'h1, "dis_reen");
    tick(2);
    rd(A_CNT, 32'd100, 1'b1, "dis_reload");
    wr(A_CTRL, 32'h0, "dis_off2");

    // Masked one-shot, then unmask clears pending
    wr(A_PRE, 32'd2, "mask_pre");
    wr(A_CTRL, 32'h1, "mask_en");
    tick(6);
    chk_irq("mask_irq", 1'b0);
    rd(A_CTRL, 32'h0, 1'b1, "mask_ctrl");
    rd(A_CNT, 32'd0, 1'b1, "mask_cnt");
    wr(A_CTRL, 32'h8, "mask_im");
    chk_irq("mask_irq_im", 1'b0);
    tick(2);
    chk_irq("mask_irq_late", 1'b0);

    // CPU CTRL write on the same edge as the one-shot EN clear
    wr(A_PRE, 32'd1, "same_pre");
    wr(A_CTRL, 32'h9, "same_en");
    tick(3);
    chk_irq("same_irq_set", 1'b1);
    wr(A_CTRL, 32'h9, "same_wr");
    chk_irq("same_irq_clr", 1'b0);
    rd(A_CTRL, 32'h9, 1'b1, "same_ctrl");
    tick(2);
    rd(A_CNT, 32'd1, 1'b1, "same_reload");
    tick(1);
    chk_irq("same_irq_again", 1'b1);
    wr(A_CTRL, 32'h0, "same_off");

    // Reset mid-count
    wr(A_PRE, 32'd50, "rc_pre");
    wr(A_CTRL, 32'h9, "rc_en");
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_irq("rc_irq", 1'b0);
    rd(A_CTRL, 32'd0, 1'b1, "rc_ctrl");
    rd(A_PRE, 32'd0, 1'b1, "rc_pre_val");
    rd(A_CNT, 32'd0, 1'b1, "rc_cnt");
    tick(3);
    rd(A_CNT, 32'd0, 1'b1, "rc_cnt_idle");

`ifdef TIMER_PRESCALE_EN
    wr(A_CTRL, 32'h10, "ps_bit4");
    rd(A_CTRL, 32'h10, 1'b1, "ps_bit4_rd");
    wr(A_PRE, 32'd4, "ps_pre");
    wr(A_CTRL, 32'h29, "ps_en");
    tick(17);
    chk_irq("ps_irq_early", 1'b0);
    rd(A_CNT, 32'd1, 1'b1, "ps_cnt_early");
    tick(1);
    chk_irq("ps_irq", 1'b1);
    rd(A_CNT, 32'd0, 1'b1, "ps_cnt_done");
`else
    wr(A_CTRL, 32'h10, "ps_bit4");
    rd(A_CTRL, 32'h0, 1'b1, "ps_bit4_rd");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
